// File: rtl/pc_sequencer_if.sv
// Control/datapath bundle between the Beta core control logic and the PC sequencer.
// master = control logic side, slave = pc_sequencer.
interface pc_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int LIT_W = 16
);
  logic             STALL;
  logic [2:0]       PCSEL;
  logic [WIDTH-1:0] JT;
  logic [LIT_W-1:0] LIT;
  logic             IRQ;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PC4;
  logic [WIDTH-1:0] PC4SXT;
  logic             SUPERVISOR;
  logic             IRQ_TAKEN;

  modport master (
    output STALL, PCSEL, JT, LIT, IRQ,
    input  PC, PC4, PC4SXT, SUPERVISOR, IRQ_TAKEN
  );

  modport slave (
    input  STALL, PCSEL, JT, LIT, IRQ,
    output PC, PC4, PC4SXT, SUPERVISOR, IRQ_TAKEN
  );
endinterface

// File: rtl/pc_sequencer.sv
// Beta-style program counter: next-PC select, supervisor-protected jumps,
// latched interrupt with supervisor deferral, and trap/reset vectors.
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter int               LIT_W     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h8000_0000),
  parameter logic [WIDTH-1:0] ILLOP_VEC = WIDTH'(32'h8000_0004),
  parameter logic [WIDTH-1:0] XADR_VEC  = WIDTH'(32'h8000_0008)
) (
  input  logic         CLK,
  input  logic         RESET,
  pc_sequencer_if.slave bus
);

  localparam logic [2:0] SEL_PC4    = 3'b000;
  localparam logic [2:0] SEL_PC4SXT = 3'b001;
  localparam logic [2:0] SEL_JT     = 3'b010;
  localparam logic [2:0] SEL_XADR   = 3'b100;

  localparam logic [WIDTH-1:0] ALIGN    = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] RESET_PC = RESET_VEC & ALIGN;
  localparam logic [WIDTH-1:0] ILLOP_PC = ILLOP_VEC & ALIGN;
  localparam logic [WIDTH-1:0] XADR_PC  = XADR_VEC & ALIGN;
  localparam logic [WIDTH-2:0] FOUR     = (WIDTH-1)'(4);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] pc4sxt;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-2:0] lit_off;
  logic             supervisor;
  logic             irq_pend;
  logic             irq_taken;
  logic             take_irq;
  logic             unused_jt_bits;

  // Arithmetic runs on the low WIDTH-1 bits so the supervisor bit never carries.
  assign supervisor = pc[WIDTH-1];
  assign lit_off    = (WIDTH-1)'($signed(bus.LIT)) << 2;
  assign pc4        = {supervisor, pc[WIDTH-2:0] + FOUR};
  assign pc4sxt     = {supervisor, pc4[WIDTH-2:0] + lit_off};
  // A jump may drop the supervisor bit but can never raise it.
  assign jump_tgt   = {supervisor & bus.JT[WIDTH-1], bus.JT[WIDTH-2:2], 2'b00};
  assign unused_jt_bits = ^bus.JT[1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    pc_next  = pc4;
    take_irq = 1'b0;
    case (bus.PCSEL)
      SEL_PC4, SEL_PC4SXT, SEL_JT: begin
        if (irq_pend && !supervisor) begin
          take_irq = 1'b1;
          pc_next  = XADR_PC;
        end else if (bus.PCSEL == SEL_PC4SXT) begin
          pc_next = pc4sxt;
        end else if (bus.PCSEL == SEL_JT) begin
          pc_next = jump_tgt;
        end else begin
          pc_next = pc4;
        end
      end
      SEL_XADR: pc_next = XADR_PC;
      default:  pc_next = ILLOP_PC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc        <= RESET_PC;
      irq_pend  <= 1'b0;
      irq_taken <= 1'b0;
    end else if (bus.STALL) begin
      irq_pend <= irq_pend | bus.IRQ;
    end else begin
      pc        <= pc_next;
      irq_taken <= take_irq;
      // A request still asserted on the take cycle re-arms the pending flag.
      irq_pend  <= (irq_pend & ~take_irq) | bus.IRQ;
    end
  end

  assign bus.PC         = pc;
  assign bus.PC4        = pc4;
  assign bus.PC4SXT     = pc4sxt;
  assign bus.SUPERVISOR = supervisor;
  assign bus.IRQ_TAKEN  = irq_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded bench for pc_sequencer: directed scenarios, then random traffic,
// checked against an arithmetic reference model of the PC rules.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h8000_0000;
  localparam logic [31:0] IV = 32'h8000_0004;
  localparam logic [31:0] XV = 32'h8000_0008;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pc4sxt;
    logic        sup;
    logic        taken;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  logic [31:0] m_pc;
  logic        m_pend;
  logic        m_taken;

  pc_sequencer_if #(.WIDTH(32), .LIT_W(16)) bus ();

  pc_sequencer #(.WIDTH(32), .LIT_W(16)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model helpers: straight from the address rules.
  function automatic logic [31:0] f_pc4(input logic [31:0] pc);
    return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  function automatic logic [31:0] f_br(input logic [31:0] pc, input logic [15:0] lit);
    int signed off;
    off = int'($signed(lit)) * 4;
    return (pc & 32'h8000_0000) | ((f_pc4(pc) + 32'(off)) & 32'h7FFF_FFFF);
  endfunction

  function automatic logic [31:0] f_jmp(input logic [31:0] pc, input logic [31:0] jt);
    logic [31:0] t;
    t = jt & 32'hFFFF_FFFC;
    if (!pc[31]) t = t & 32'h7FFF_FFFF;
    return t;
  endfunction

  // One clock cycle: drive inputs, optionally record expected outputs, advance model.
  task automatic step(input logic r, input logic s, input logic [2:0] sel,
                      input logic [31:0] jt, input logic [15:0] lit,
                      input logic irq, input bit chk);
    exp_t e;
    logic [31:0] nxt;
    logic        tk;
    rst = r; bus.STALL = s; bus.PCSEL = sel; bus.JT = jt; bus.LIT = lit; bus.IRQ = irq;
    if (chk) begin
      e.pc = m_pc; e.pc4 = f_pc4(m_pc); e.pc4sxt = f_br(m_pc, lit);
      e.sup = m_pc[31]; e.taken = m_taken;
      exp_q.push_back(e);
    end
    if (r) begin
      m_pc = RV; m_pend = 1'b0; m_taken = 1'b0;
    end else if (s) begin
      m_pend = m_pend | irq;
    end else begin
      tk = 1'b0;
      if (sel == 3'd4)      nxt = XV;
      else if (sel >= 3'd3) nxt = IV;
      else if (m_pend && !m_pc[31]) begin
        nxt = XV; tk = 1'b1; m_pend = 1'b0;
      end
      else if (sel == 3'd1) nxt = f_br(m_pc, lit);
      else if (sel == 3'd2) nxt = f_jmp(m_pc, jt);
      else                  nxt = f_pc4(m_pc);
      m_pc = nxt; m_taken = tk; m_pend = m_pend | irq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [2:0] sel, input logic [31:0] jt, input logic [15:0] lit, input logic irq);
    step(1'b0, 1'b0, sel, jt, lit, irq, 1'b1);
  endtask

  // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("PC",         bus.PC,                e.pc);
      check("PC4",        bus.PC4,               e.pc4);
      check("PC4SXT",     bus.PC4SXT,            e.pc4sxt);
      check("SUPERVISOR", 32'(bus.SUPERVISOR),   32'(e.sup));
      check("IRQ_TAKEN",  32'(bus.IRQ_TAKEN),    32'(e.taken));
    end
  end

  initial begin
    m_pc = 32'h0; m_pend = 1'b0; m_taken = 1'b0;
    // Reset then free-run.
    step(1'b1, 1'b0, 3'd0, 32'h0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'd0, 32'h0, 16'h0, 1'b0, 1'b1);
    repeat (3) run(3'd0, 32'h0, 16'h0, 1'b0);
    // Negative branch from 80000100, then stall.
    run(3'd2, 32'h8000_0100, 16'h0, 1'b0);
    run(3'd1, 32'h0, 16'hFFFE, 1'b0);
    step(1'b0, 1'b1, 3'd0, 32'h0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 3'd0, 32'h0, 16'h0, 1'b0, 1'b1);
    run(3'd0, 32'h0, 16'h0, 1'b0);
    // Jump privilege: supervisor then user.
    run(3'd2, 32'h8000_0040, 16'h0, 1'b0);
    run(3'd2, 32'h8000_1003, 16'h0, 1'b0);
    run(3'd2, 32'h0000_0040, 16'h0, 1'b0);
    run(3'd2, 32'h8000_1003, 16'h0, 1'b0);
    run(3'd0, 32'h0, 16'h0, 1'b0);
    // User-mode interrupt arriving while PC=1FC, taken from PC=200.
    run(3'd2, 32'h0000_01FC, 16'h0, 1'b0);
    run(3'd0, 32'h0, 16'h0, 1'b1);
    run(3'd0, 32'h0, 16'h0, 1'b0);
    repeat (3) run(3'd0, 32'h0, 16'h0, 1'b0);
    // Deferral in supervisor mode, then release by jumping to user space.
    run(3'd0, 32'h0, 16'h0, 1'b1);
    repeat (3) run(3'd0, 32'h0, 16'h0, 1'b0);
    run(3'd2, 32'h0000_0300, 16'h0, 1'b0);
    run(3'd0, 32'h0, 16'h0, 1'b0);
    run(3'd0, 32'h0, 16'h0, 1'b0);
    // Pending interrupt loses to an ILLOP trap and stays pending.
    run(3'd2, 32'h0000_0400, 16'h0, 1'b0);
    run(3'd0, 32'h0, 16'h0, 1'b1);
    run(3'd3, 32'h0, 16'h0, 1'b0);
    run(3'd4, 32'h0, 16'h0, 1'b0);
    run(3'd2, 32'h0000_0500, 16'h0, 1'b0);
    run(3'd0, 32'h0, 16'h0, 1'b0);
    run(3'd0, 32'h0, 16'h0, 1'b0);
    // Undefined select, wrap-around in both modes.
    run(3'd6, 32'h0, 16'h0, 1'b0);
    run(3'd2, 32'h7FFF_FFFC, 16'h0, 1'b0);
    run(3'd0, 32'h0, 16'h0, 1'b0);
    run(3'd3, 32'h0, 16'h0, 1'b0);
    run(3'd2, 32'hFFFF_FFFC, 16'h0, 1'b0);
    run(3'd0, 32'h0, 16'h0, 1'b0);
    run(3'd0, 32'h0, 16'h0, 1'b0);
    // Reset overrides stall and discards a pending interrupt.
    run(3'd2, 32'h0000_0600, 16'h0, 1'b1);
    step(1'b1, 1'b1, 3'd3, 32'h0, 16'h0, 1'b0, 1'b1);
    run(3'd2, 32'h0000_0700, 16'h0, 1'b0);
    repeat (3) run(3'd0, 32'h0, 16'h0, 1'b0);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] sel;
      int pick;
      pick = int'($urandom_range(0, 99));
      if (pick < 35)      sel = 3'd0;
      else if (pick < 55) sel = 3'd1;
      else if (pick < 85) sel = 3'd2;
      else                sel = 3'($urandom_range(3, 7));
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 15), sel,
           $urandom(), 16'($urandom()), ($urandom_range(0, 99) < 10), 1'b1);
    end
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the Beta-style unpipelined core. It merges the next-PC select, the reset-vector override and the PC register into one clocked block. It adds the following to plain next-PC selection:
- stall hold
- a latched external interrupt
- supervisor-bit protection on jumps and branches
- configurable reset and exception vectors

It feeds instruction memory, and the PC4 and PC4SXT operands, to the A and write-data selectors.

## Interface
Parameters:
- WIDTH, 32, address width; bit WIDTH-1 is the supervisor bit; minimum 8.
- LIT_W, 16, width of the signed branch literal.
- RESET_VEC, 32'h80000000, PC value after reset.
- ILLOP_VEC, 32'h80000004, illegal-opcode trap target.
- XADR_VEC, 32'h80000008, interrupt target.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  hold the PC and the pending interrupt this cycle.
- PCSEL  in  3  next-PC source: 000 PC4, 001 PC4SXT, 010 JT, 011 ILLOP, 100 XADR; 101–111 are treated as ILLOP.
- JT  in  WIDTH  jump target (register RD1).
- LIT  in  LIT_W  signed word offset from the instruction's literal field.
- IRQ  in  1  level interrupt request.
- PC  out  WIDTH  current PC register.
- PC4  out  WIDTH  PC+4 with the supervisor bit preserved.
- PC4SXT  out  WIDTH  branch target.
- SUPERVISOR  out  1  equals PC[WIDTH-1].
- IRQ_TAKEN  out  1  one-cycle pulse in the cycle after the PC was loaded with XADR_VEC.

## Operation
Arithmetic, all on the low WIDTH-1 bits:
- PC4 = {PC[W-1], (PC[W-2:0]+4) mod 2^(W-1)}.
- PC4SXT = {PC[W-1], (PC4[W-2:0] + (SXT(LIT)<<2)) mod 2^(W-1)}.
- The branch path never changes the supervisor bit.
- Jump target = {PC[W-1] & JT[W-1], JT[W-2:2], 2'b00`}. A jump can leave supervisor mode but never enter it.
- Every value loaded into PC has bits [1:0] forced to 00, including vectors.

Pending interrupt (`irq_pend`):
- Set on any cycle where IRQ=1, including stalled cycles.
- Cleared only when the interrupt is taken, or on RESET.

Next-PC priority, highest first:
1. RESET: PC←RESET_VEC, irq_pend←0, IRQ_TAKEN←0. RESET overrides STALL.
2. STALL: PC and IRQ_TAKEN hold. irq_pend may still set.
3. Trap selects:
   - PCSEL=011 or 101–111: PC←ILLOP_VEC.
   - PCSEL=100: PC←XADR_VEC.
   - irq_pend is left unchanged; the interrupt is deferred.
4. Take interrupt when irq_pend=1 and SUPERVISOR=0:
   - PC←XADR_VEC; this replaces the PCSEL 000/001/010 target.
   - irq_pend←0.
   - IRQ_TAKEN←1 next cycle.
   - The PC4 output this cycle is the XP return value; the handler returns to XP-4.
5. Otherwise: PC←PC4, PC4SXT or jump target per PCSEL.

Other rules:
- Interrupts are never taken while SUPERVISOR=1. They stay pending until the PC returns to user mode.
- A PCSEL=100 trap does not clear irq_pend and does not raise IRQ_TAKEN.

## Timing
- PC, irq_pend and IRQ_TAKEN are registers. PC4, PC4SXT, jump target, SUPERVISOR and the next-PC mux are combinational from PC, JT, LIT and PCSEL.
- Latency:
  - PCSEL/JT/LIT presented in cycle n appear on PC in cycle n+1.
  - IRQ asserted in cycle n can redirect PC at the earliest at the edge ending cycle n+1, because it passes through irq_pend.
- Reset values: PC=RESET_VEC & ~3, SUPERVISOR=RESET_VEC[W-1], IRQ_TAKEN=0, irq_pend=0. These hold for every cycle RESET is high.
- Reset mid-operation discards any pending interrupt and any trap selected in the same cycle.
- Wrap-around: PC=32'h7FFFFFFC with PCSEL=000 gives next PC=32'h00000000, staying in user mode. PC=32'hFFFFFFFC gives 32'h80000000.

## Test plan
- Reset then free-run: RESET=1 for 2 cycles, then PCSEL=000 for 3 cycles → PC = 80000000, 80000004, 80000008, 8000000C; IRQ_TAKEN=0 throughout.
- Branch with negative offset: PC=80000100, LIT=16'hFFFE, PCSEL=001 → PC4SXT=800000FC and next PC=800000FC. Then STALL=1 for 2 cycles → PC holds at 800000FC.
- Jump privilege:
  - User PC=00000040, JT=80001003, PCSEL=010 → next PC=00001000.
  - Supervisor PC=80000040, same JT → next PC=80001000.
- Interrupt while in user mode at PC=00000200:
  - IRQ pulse for one cycle → PC=80000008 on the following edge.
  - PC4 output before that edge = 00000204.
  - IRQ_TAKEN high exactly one cycle.
  - irq_pend clears.
- Interrupt deferral:
  - IRQ pulsed while SUPERVISOR=1 → no redirect while in supervisor mode.
  - JMP to user address 00000300 → next cycle PC=80000008 with IRQ_TAKEN.
  - Same IRQ with simultaneous PCSEL=011 → ILLOP_VEC first, interrupt stays pending.
- Undefined selects and reset overrides: PCSEL=110 → PC=80000004. RESET=1 together with STALL=1 and a pending IRQ → PC=80000000, pending cleared, no IRQ_TAKEN afterwards.
